// File: rtl/cv_pkg.sv
// ============================================================================
//  Module  : cv_pkg
//  Brief   : Shared constants and walker state encoding for the cv pipeline.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cv_pkg;

  localparam int CV_XW = 12;

  typedef enum logic {
    CVW_IDLE = 1'b0,
    CVW_WALK = 1'b1
  } cvw_state_e;

endpackage : cv_pkg

`default_nettype wire

// File: rtl/cvspanwalk_if.sv
// ============================================================================
//  Module  : cvspanwalk_if
//  Brief   : Span descriptor input and per-pixel output bundle of the walker.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface cvspanwalk_if
  import cv_pkg::*;
#(
  parameter int XW = CV_XW
);

  logic          span_load;
  logic [XW-1:0] span_xstart;
  logic [XW-1:0] span_xend;
  logic          span_ltor;
  logic [XW-1:0] scis_xmin;
  logic [XW-1:0] scis_xmax;
  logic          span_ready;
  logic          new_span;
  logic          valid_pixel_m;
  logic [XW-1:0] pix_x;
  logic          pix_active;
  logic          span_done;

  modport master (
    output span_load, span_xstart, span_xend, span_ltor, scis_xmin, scis_xmax,
    input  span_ready, new_span, valid_pixel_m, pix_x, pix_active, span_done
  );

  modport slave (
    input  span_load, span_xstart, span_xend, span_ltor, scis_xmin, scis_xmax,
    output span_ready, new_span, valid_pixel_m, pix_x, pix_active, span_done
  );

endinterface : cvspanwalk_if

`default_nettype wire

// File: rtl/cvxclip.sv
// ============================================================================
//  Module  : cvxclip
//  Brief   : Combinational inclusive unsigned range test, xmin <= x <= xmax.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cvxclip
  import cv_pkg::*;
#(
  parameter int XW = CV_XW
) (
  input  logic [XW-1:0] x,
  input  logic [XW-1:0] xmin,
  input  logic [XW-1:0] xmax,
  output logic          in_range
);

  // An inverted window (xmin > xmax) naturally yields 0 for every x.
  assign in_range = (x >= xmin) && (x <= xmax);

endmodule : cvxclip

`default_nettype wire

// File: rtl/cvspanwalk.sv
// ============================================================================
//  Module  : cvspanwalk
//  Brief   : Walks one span in X, one pixel per gclk, with scissor-valid flag.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cvspanwalk
  import cv_pkg::*;
#(
  parameter int XW = CV_XW
) (
  input  logic         gclk,
  input  logic         reset,
  cvspanwalk_if.slave  bus
);

  localparam logic [XW-1:0] X_ONE = XW'(1);

  cvw_state_e    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [XW-1:0] xend_q, xend_d;
  logic          ltor_q, ltor_d;
  logic          new_q, new_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;
  logic          ready_q, ready_d;

  logic          accept;
  logic          force_inv;
  logic          x_in;
  logic [XW:0]   len;
  logic [XW-1:0] x_step;

  // Next-state / next-output logic; the extra len bit flags a backwards span.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    xend_d    = xend_q;
    ltor_d    = ltor_q;
    new_d     = 1'b0;
    done_d    = 1'b0;
    force_inv = 1'b0;

    accept = bus.span_load & ready_q;
    len    = bus.span_ltor ? ({1'b0, bus.span_xend} - {1'b0, bus.span_xstart})
                           : ({1'b0, bus.span_xstart} - {1'b0, bus.span_xend});
    x_step = ltor_q ? (x_q + X_ONE) : (x_q - X_ONE);

    if (accept) begin
      state_d   = CVW_WALK;
      x_d       = bus.span_xstart;
      xend_d    = bus.span_xend;
      ltor_d    = bus.span_ltor;
      new_d     = 1'b1;
      done_d    = len[XW] | (len[XW-1:0] == '0);
      force_inv = len[XW];
    end else if (state_q == CVW_WALK && !done_q) begin
      x_d    = x_step;
      done_d = (x_step == xend_q);
    end else begin
      state_d = CVW_IDLE;
    end

    ready_d = (state_d == CVW_IDLE) | done_d;
  end

  cvxclip #(
    .XW (XW)
  ) u_xclip (
    .x        (x_d),
    .xmin     (bus.scis_xmin),
    .xmax     (bus.scis_xmax),
    .in_range (x_in)
  );

  always_comb begin
    valid_d = (state_d == CVW_WALK) & ~force_inv & x_in;
  end

  always_ff @(posedge gclk or negedge reset) begin
    if (!reset) begin
      state_q <= CVW_IDLE;
      x_q     <= '0;
      xend_q  <= '0;
      ltor_q  <= 1'b0;
      new_q   <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      xend_q  <= xend_d;
      ltor_q  <= ltor_d;
      new_q   <= new_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign bus.span_ready    = ready_q;
  assign bus.new_span      = new_q;
  assign bus.valid_pixel_m = valid_q;
  assign bus.pix_x         = x_q;
  assign bus.pix_active    = (state_q == CVW_WALK);
  assign bus.span_done     = done_q;

endmodule : cvspanwalk

`default_nettype wire

// File: tb/tb_cvspanwalk.sv
// ============================================================================
//  Module  : tb_cvspanwalk
//  Brief   : Self-checking bench for cvspanwalk against a span-level model.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cvspanwalk;
  import cv_pkg::*;

  localparam int XW = CV_XW;

  logic gclk  = 1'b0;
  logic reset = 1'b0;

  cvspanwalk_if #(.XW(XW)) bus();

  cvspanwalk #(.XW(XW)) dut (
    .gclk  (gclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 gclk = ~gclk;

  int n_chk  = 0;
  int n_fail = 0;
  int sc_min, sc_max, m_x;

  // Expected output stream, one entry per cycle, plus which span to load that cycle.
  logic [XW+4:0] q_exp[$];
  int            q_ld[$];
  int            s_xs[$];
  int            s_xe[$];
  bit            s_lt[$];

  function automatic logic [XW+4:0] pk(input bit a, input bit n, input bit d,
                                       input bit v, input bit r, input int x);
    return {a, n, d, v, r, XW'(x)};
  endfunction

  function automatic logic [XW+4:0] obs();
    return {bus.pix_active, bus.new_span, bus.span_done, bus.valid_pixel_m,
            bus.span_ready, bus.pix_x};
  endfunction

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  function automatic void clear_model();
    q_exp.delete();
    q_ld.delete();
    s_xs.delete();
    s_xe.delete();
    s_lt.delete();
  endfunction

  function automatic void set_scis(input int mn, input int mx);
    sc_min        = mn;
    sc_max        = mx;
    bus.scis_xmin = XW'(mn);
    bus.scis_xmax = XW'(mx);
  endfunction

  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      q_exp.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_x));
      q_ld.push_back(-1);
    end
  endfunction

  // Span model: pixel count from the signed distance along the walk direction.
  function automatic void add_span(input int xs, input int xe, input bit lt, input bit chain);
    int len;
    int x;
    s_xs.push_back(xs);
    s_xe.push_back(xe);
    s_lt.push_back(lt);
    if (!chain || q_ld.size() == 0) add_idle(1);
    q_ld[q_ld.size()-1] = s_xs.size() - 1;
    len = lt ? (xe - xs) : (xs - xe);
    if (len < 0) begin
      q_exp.push_back(pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, xs));
      q_ld.push_back(-1);
      m_x = xs;
    end else begin
      for (int i = 0; i <= len; i++) begin
        x = lt ? (xs + i) : (xs - i);
        q_exp.push_back(pk(1'b1, i == 0, i == len, (sc_min <= x) && (x <= sc_max), i == len, x));
        q_ld.push_back(-1);
        m_x = x;
      end
    end
  endfunction

  task automatic drive(input int c);
    int k;
    k = q_ld[c];
    if (k >= 0) begin
      bus.span_load   = 1'b1;
      bus.span_xstart = XW'(s_xs[k]);
      bus.span_xend   = XW'(s_xe[k]);
      bus.span_ltor   = s_lt[k];
    end else begin
      bus.span_load   = 1'b0;
      bus.span_xstart = XW'($urandom);
      bus.span_xend   = XW'($urandom);
      bus.span_ltor   = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    bus.span_load = 1'b0;
    bus.span_xstart = '0;
    bus.span_xend = '0;
    bus.span_ltor = 1'b0;
    set_scis(0, 4095);
    reset = 1'b0;
    repeat (3) tick();
    n_chk++;
    if (obs() !== pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0)) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected %h", obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0));
    end
    reset = 1'b1;
    tick();
    m_x = 0;
    n_chk++;
    if (obs() !== pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0)) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0));
    end
  endtask

  task automatic test_ltor();
    clear_model();
    set_scis(0, 4095);
    add_span(10, 13, 1'b1, 1'b0);
    add_idle(2);
    for (int c = 0; c < q_exp.size(); c++) begin
      n_chk++;
      if (obs() !== q_exp[c]) begin
        n_fail++;
        $display("FAIL ltor c%0d: got %h expected %h", c, obs(), q_exp[c]);
      end
      drive(c);
      tick();
    end
  endtask

  task automatic test_rtol_scissor();
    clear_model();
    set_scis(18, 30);
    add_span(20, 16, 1'b0, 1'b0);
    add_idle(1);
    for (int c = 0; c < q_exp.size(); c++) begin
      n_chk++;
      if (obs() !== q_exp[c]) begin
        n_fail++;
        $display("FAIL rtol_scissor c%0d: got %h expected %h", c, obs(), q_exp[c]);
      end
      drive(c);
      tick();
    end
  endtask

  task automatic test_back_to_back();
    clear_model();
    set_scis(0, 4095);
    add_span(10, 13, 1'b1, 1'b0);
    add_span(5, 5, 1'b1, 1'b1);
    add_idle(2);
    for (int c = 0; c < q_exp.size(); c++) begin
      n_chk++;
      if (obs() !== q_exp[c]) begin
        n_fail++;
        $display("FAIL back_to_back c%0d: got %h expected %h", c, obs(), q_exp[c]);
      end
      drive(c);
      tick();
    end
  endtask

  task automatic test_degenerate();
    clear_model();
    set_scis(0, 4095);
    add_span(8, 3, 1'b1, 1'b0);
    add_idle(1);
    add_span(100, 98, 1'b1, 1'b0);
    add_span(7, 9, 1'b1, 1'b1);
    add_span(4, 6, 1'b0, 1'b1);
    add_idle(2);
    for (int c = 0; c < q_exp.size(); c++) begin
      n_chk++;
      if (obs() !== q_exp[c]) begin
        n_fail++;
        $display("FAIL degenerate c%0d: got %h expected %h", c, obs(), q_exp[c]);
      end
      drive(c);
      tick();
    end
  endtask

  task automatic test_reset_mid_span();
    clear_model();
    set_scis(0, 4095);
    add_span(40, 49, 1'b1, 1'b0);
    for (int c = 0; c <= 3; c++) begin
      n_chk++;
      if (obs() !== q_exp[c]) begin
        n_fail++;
        $display("FAIL reset_mid c%0d: got %h expected %h", c, obs(), q_exp[c]);
      end
      if (c < 3) begin
        drive(c);
        tick();
      end
    end
    reset = 1'b0;
    #1;
    m_x = 0;
    n_chk++;
    if (obs() !== pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0)) begin
      n_fail++;
      $display("FAIL reset_mid_abort: got %h expected %h", obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0));
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++;
      if (obs() !== pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0)) begin
        n_fail++;
        $display("FAIL reset_mid_idle%0d: got %h expected %h", i, obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0));
      end
    end
    clear_model();
    add_span(3, 6, 1'b1, 1'b0);
    add_idle(1);
    for (int c = 0; c < q_exp.size(); c++) begin
      n_chk++;
      if (obs() !== q_exp[c]) begin
        n_fail++;
        $display("FAIL reset_mid_restart c%0d: got %h expected %h", c, obs(), q_exp[c]);
      end
      drive(c);
      tick();
    end
  endtask

  task automatic test_random();
    int xs, xe, off;
    for (int r = 0; r < 4; r++) begin
      clear_model();
      if (r == 3) set_scis(60, 20);
      else set_scis(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
      for (int k = 0; k < 8; k++) begin
        xs  = (sc_min + int'($urandom_range(0, 40)) - 20) & 4095;
        if (k == 0 && r == 0) xs = 4090;
        off = int'($urandom_range(0, 24)) - 12;
        xe  = (xs + off) & 4095;
        if ($urandom_range(0, 1) == 0 && k > 0) begin
          add_span(xs, xe, 1'($urandom), 1'b1);
        end else begin
          add_idle(int'($urandom_range(0, 2)));
          add_span(xs, xe, 1'($urandom), 1'b0);
        end
      end
      add_idle(2);
      for (int c = 0; c < q_exp.size(); c++) begin
        n_chk++;
        if (obs() !== q_exp[c]) begin
          n_fail++;
          $display("FAIL random r%0d c%0d: got %h expected %h", r, c, obs(), q_exp[c]);
        end
        drive(c);
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_ltor();
    test_rtol_scissor();
    test_back_to_back();
    test_degenerate();
    test_reset_mid_span();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_cvspanwalk

`default_nettype wire
